uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a CPU write port and a UART transmitter.
// A small FSM pops one byte at a time and handshakes it out with tx_start/tx_busy.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    wr_data,
    input  logic          wr_strobe,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy
);

    localparam int unsigned CW        = AW + 1;
    localparam int unsigned TW        = 2;
    localparam int unsigned TMO_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [TW-1:0]  tmo_q;
    logic [TW-1:0]  tmo_d;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count_d;
    logic           push_c;
    logic           pop_c;

    // Full is the registered flag, so a same-cycle pop never frees a slot for the push.
    always_comb begin
        push_c = wr_strobe && !full;
    end

    always_comb begin
        count_d = count;
        if (push_c && !pop_c) begin
            count_d = count + CW'(1);
        end else if (!push_c && pop_c) begin
            count_d = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic; a silent transmitter is given up on after TMO_LIMIT cycles.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop_c   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TW'(TMO_LIMIT - 1)) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr  <= rd_ptr + AW'(1);
                tx_data <= mem[rd_ptr];
            end
            if (wr_strobe && full) begin
                overflow <= 1'b1;
            end
            count    <= count_d;
            full     <= (count_d == CW'(DEPTH));
            empty    <= (count_d == '0);
            tx_start <= (state_d == START);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a cycle-counted transmitter busy model.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    wr_data;
    logic          wr_strobe;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            starts = 0;
    int            last_start = -1000;
    int            busy_len = 10;
    bit            model_en = 1'b0;
    bit            hold_busy = 1'b0;
    bit            gap_chk = 1'b0;
    bit            mon_en = 1'b0;
    logic [7:0]    sent [$];

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_strobe (wr_strobe),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy for busy_len cycles starting one cycle after tx_start.
    task automatic drive_busy();
        tx_busy = hold_busy || (model_en && (cyc > last_start) && (cyc <= last_start + busy_len));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mon_en) begin
            chk("full_vs_count", 32'(full), 32'(count == (AW+1)'(DEPTH)));
            chk("empty_vs_count", 32'(empty), 32'(count == '0));
            chk("count_max", 32'(count <= (AW+1)'(DEPTH)), 32'd1);
        end
        if (tx_start === 1'b1) begin
            if (gap_chk) begin
                chk("start_gap", 32'((cyc - last_start) > busy_len + 1), 32'd1);
            end
            starts++;
            sent.push_back(tx_data);
            last_start = cyc;
        end
        drive_busy();
    endtask

    task automatic push(input logic [7:0] b);
        wr_data   = b;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        wr_strobe = 1'b0;
        wr_data   = 8'h00;
        tx_busy   = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Single byte latency
        model_en = 1'b1;
        busy_len = 10;
        gap_chk  = 1'b1;
        sent.delete();
        starts = 0;
        push(8'h41);
        chk("single_no_early_start", 32'(tx_start), 32'd0);
        tick();
        chk("single_start_n2", 32'(tx_start), 32'd1);
        chk("single_data", 32'(tx_data), 32'h41);
        repeat (15) tick();
        chk("single_one_start", 32'(starts), 32'd1);
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_data_hold", 32'(tx_data), 32'h41);

        // Burst fill while the transmitter is held busy
        sent.delete();
        starts    = 0;
        hold_busy = 1'b1;
        drive_busy();
        for (int i = 0; i < 16; i++) begin
            wr_data   = 8'(i + 1);
            wr_strobe = 1'b1;
            tick();
        end
        wr_strobe = 1'b0;
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_count", 32'(count), 32'd16);
        chk("burst_not_empty", 32'(empty), 32'd0);

        // Overflow while full
        push(8'hEE);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_full", 32'(full), 32'd1);

        // Pop in the same cycle does not make room for a push
        hold_busy = 1'b0;
        drive_busy();
        wr_data   = 8'hEF;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        chk("popfull_count", 32'(count), 32'd15);
        chk("popfull_full", 32'(full), 32'd0);
        for (int g = 0; g < 400 && sent.size() < 16; g++) tick();
        repeat (30) tick();
        chk("burst_sent_count", 32'(sent.size()), 32'd16);
        for (int i = 0; i < 16 && i < sent.size(); i++) begin
            chk("burst_order", 32'(sent[i]), 32'(i + 1));
        end
        chk("burst_ovf_sticky", 32'(overflow), 32'd1);
        chk("burst_empty", 32'(empty), 32'd1);

        // Wrap with pushes landing on pop cycles
        sent.delete();
        starts   = 0;
        busy_len = 2;
        for (int i = 0; i < 8; i++) begin
            wr_data   = 8'(8'h80 + i);
            wr_strobe = 1'b1;
            tick();
        end
        wr_strobe = 1'b0;
        for (int g = 0; g < 20 && tx_start !== 1'b1; g++) tick();
        chk("wrap_sync", 32'(tx_start), 32'd1);
        for (int k = 0; k < 32; k++) begin
            repeat (4) tick();
            wr_data   = 8'(8'h88 + k);
            wr_strobe = 1'b1;
            tick();
            wr_strobe = 1'b0;
            chk("wrap_lockstep", 32'(tx_start), 32'd1);
            chk("wrap_count_range", 32'((count >= 5'd1) && (count <= 5'd15)), 32'd1);
        end
        for (int g = 0; g < 400 && sent.size() < 40; g++) tick();
        repeat (10) tick();
        chk("wrap_sent_count", 32'(sent.size()), 32'd40);
        for (int i = 0; i < 40 && i < sent.size(); i++) begin
            chk("wrap_order", 32'(sent[i]), 32'(8'h80 + i));
        end

        // Timeout with tx_busy tied low
        model_en = 1'b0;
        gap_chk  = 1'b0;
        drive_busy();
        repeat (5) tick();
        sent.delete();
        starts = 0;
        push(8'h55);
        tick();
        chk("tmo_start", 32'(tx_start), 32'd1);
        chk("tmo_data", 32'(tx_data), 32'h55);
        wr_data   = 8'hAA;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        chk("tmo_single_pulse", 32'(tx_start), 32'd0);
        for (int j = 2; j <= 5; j++) begin
            tick();
            chk("tmo_wait_no_start", 32'(tx_start), 32'd0);
            chk("tmo_data_hold", 32'(tx_data), 32'h55);
        end
        tick();
        chk("tmo_second_start", 32'(tx_start), 32'd1);
        chk("tmo_second_data", 32'(tx_data), 32'hAA);
        repeat (8) tick();
        chk("tmo_starts", 32'(starts), 32'd2);
        chk("tmo_empty", 32'(empty), 32'd1);

        // Reset during WAIT_DONE with bytes queued
        model_en = 1'b1;
        busy_len = 10;
        gap_chk  = 1'b1;
        drive_busy();
        sent.delete();
        starts = 0;
        chk("mid_ovf_before", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) push(8'(8'hC1 + i));
        chk("mid_count_queued", 32'(count), 32'd3);
        chk("mid_one_start", 32'(starts), 32'd1);
        repeat (2) tick();
        rst_n     = 1'b0;
        wr_data   = 8'hDD;
        wr_strobe = 1'b1;
        tick();
        rst_n     = 1'b1;
        wr_strobe = 1'b0;
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_full", 32'(full), 32'd0);
        chk("mid_tx_start", 32'(tx_start), 32'd0);
        chk("mid_overflow", 32'(overflow), 32'd0);
        chk("mid_tx_data", 32'(tx_data), 32'h00);
        repeat (40) tick();
        chk("mid_no_more_starts", 32'(starts), 32'd1);
        chk("mid_still_empty", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
